lsu_mem_ctrl: RTL

//  Load/store access sequencer between core control and data memory. Latches a load/store

---
 rtl/lsu_mem_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store access sequencer between the core and data memory.
// A request is decoded and latched in IDLE. Legal accesses drive one word-aligned
// memory cycle with big-endian byte enables and lane-replicated store data, then wait
// for mem_ready under a bounded wait counter. Misaligned or illegal-funct3 requests
// pulse fault without touching the bus. The raw read word, the request IR and the
// byte offset are held for the downstream load-data converter.

`default_nettype none

module lsu_mem_ctrl #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] ir,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        timeout,
   output logic [31:0] ir_q,
   output logic [1:0]  offset,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      FAULT  = 2'd2
   } state_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   // Last ACCESS cycle index before the wait budget runs out.
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t      r_state;
   logic [7:0]  r_waitCnt;
   logic        r_done;
   logic        r_fault;
   logic        r_timeout;
   logic [31:0] r_irQ;
   logic [1:0]  r_offset;
   logic [31:0] r_rdata;
   logic [31:0] r_memAddr;
   logic        r_memRd;
   logic        r_memWr;
   logic [3:0]  r_memBe;
   logic [31:0] r_memWdata;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_isLoad;
   logic        w_isStore;
   logic        w_funct3Ok;
   logic        w_alignOk;
   logic        w_legal;
   logic        w_canAccept;
   logic [3:0]  w_be;
   logic [31:0] w_laneData;

   assign w_opcode  = ir[6:0];
   assign w_funct3  = ir[14:12];
   assign w_isLoad  = (w_opcode == OPC_LOAD);
   assign w_isStore = (w_opcode == OPC_STORE);

   // The fault cycle already counts as idle, so a new request can be taken there too.
   assign w_canAccept = (r_state != ACCESS);

   // Decode legality, byte enables and lane-replicated store data from the incoming request.
   always_comb begin
      w_funct3Ok = 1'b0;
      w_alignOk  = 1'b1;
      w_be       = 4'b1111;
      w_laneData = wdata;
      if (w_isLoad) begin
         w_funct3Ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
      end else if (w_isStore) begin
         w_funct3Ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
      end
      case (w_funct3[1:0])
         2'b00: begin
            w_be       = 4'b1000 >> addr[1:0];
            w_laneData = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_alignOk  = (addr[0] == 1'b0);
            w_be       = 4'b1100 >> addr[1:0];
            w_laneData = {2{wdata[15:0]}};
         end
         default: begin
            w_alignOk  = (addr[1:0] == 2'b00);
            w_be       = 4'b1111;
            w_laneData = wdata;
         end
      endcase
      w_legal = w_funct3Ok && w_alignOk;
   end

   // Access sequencer: accepts requests, runs the bus cycle and produces the status pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_waitCnt  <= 8'd0;
         r_done     <= 1'b0;
         r_fault    <= 1'b0;
         r_timeout  <= 1'b0;
         r_irQ      <= 32'd0;
         r_offset   <= 2'd0;
         r_rdata    <= 32'd0;
         r_memAddr  <= 32'd0;
         r_memRd    <= 1'b0;
         r_memWr    <= 1'b0;
         r_memBe    <= 4'd0;
         r_memWdata <= 32'd0;
      end else begin
         r_done    <= 1'b0;
         r_fault   <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ACCESS: begin
               if (mem_ready) begin
                  if (r_memRd) begin
                     r_rdata <= mem_rdata;
                  end
                  r_done  <= 1'b1;
                  r_memRd <= 1'b0;
                  r_memWr <= 1'b0;
                  r_state <= IDLE;
               end else if (r_waitCnt == LAST_WAIT) begin
                  r_timeout <= 1'b1;
                  r_memRd   <= 1'b0;
                  r_memWr   <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_waitCnt <= r_waitCnt + 8'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               if (req && w_canAccept) begin
                  r_irQ    <= ir;
                  r_offset <= addr[1:0];
                  if (w_legal) begin
                     r_state    <= ACCESS;
                     r_waitCnt  <= 8'd0;
                     r_memAddr  <= {addr[31:2], 2'b00};
                     r_memBe    <= w_be;
                     r_memWdata <= w_isStore ? w_laneData : 32'd0;
                     r_memRd    <= w_isLoad;
                     r_memWr    <= w_isStore;
                  end else begin
                     r_state <= FAULT;
                     r_fault <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign fault     = r_fault;
   assign timeout   = r_timeout;
   assign ir_q      = r_irQ;
   assign offset    = r_offset;
   assign rdata     = r_rdata;
   assign mem_addr  = r_memAddr;
   assign mem_rd    = r_memRd;
   assign mem_wr    = r_memWr;
   assign mem_be    = r_memBe;
   assign mem_wdata = r_memWdata;

endmodule

`default_nettype wire
